// File: rtl/mlp_pkg.sv
// Shared types and the post-accumulation scaling for the MLP layer sequencer.
// Imported by the sequencer and its bus interface.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FLUSH,
    WRITE,
    DONE
  } state_e;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 33;
  localparam int OUT_W  = 16;

  localparam logic signed [ACC_W-1:0] SAT_HI = 33'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_LO = -33'sd32768;

  // Shift first, then clamp to the output range, then optional ReLU.
  function automatic logic signed [OUT_W-1:0] sat_relu(
    input logic signed [ACC_W-1:0] acc,
    input int unsigned             shift,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] v;
    v = acc >>> shift;
    if (v > SAT_HI) begin
      v = SAT_HI;
    end else if (v < SAT_LO) begin
      v = SAT_LO;
    end
    if (relu && v < 0) begin
      v = '0;
    end
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Control, RAM and MAC bus of the layer sequencer.
// master = sequencer side, slave = RAMs/MAC/host side.
interface mlp_layer_sequencer_if #(
  parameter int IN_AW = 10,
  parameter int W_AW  = 13
);
  import mlp_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [3:0]               digit;
  logic [IN_AW-1:0]         x_addr;
  logic signed [DATA_W-1:0] x_rdata;
  logic [W_AW-1:0]          w_addr;
  logic signed [DATA_W-1:0] w_rdata;
  logic                     mac_clken;
  logic                     mac_sload;
  logic signed [DATA_W-1:0] mac_dataa;
  logic signed [DATA_W-1:0] mac_datab;
  logic signed [ACC_W-1:0]  mac_result;
  logic                     out_we;
  logic [3:0]               out_addr;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    input  start, x_rdata, w_rdata, mac_result,
    output busy, done, digit, x_addr, w_addr,
    output mac_clken, mac_sload, mac_dataa, mac_datab,
    output out_we, out_addr, out_data
  );

  modport slave (
    output start, x_rdata, w_rdata, mac_result,
    input  busy, done, digit, x_addr, w_addr,
    input  mac_clken, mac_sload, mac_dataa, mac_datab,
    input  out_we, out_addr, out_data
  );

endinterface

// File: rtl/mlp_layer_sequencer.sv
// Drives an external MAC through one fully connected layer and
// tracks the arg-max neuron as the recognized digit.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int LEN     = 784,
  parameter int NEURONS = 10,
  parameter int IN_AW   = 10,
  parameter int W_AW    = 13,
  parameter int SHIFT   = 8,
  parameter int RELU    = 1
) (
  input logic                   clk,
  input logic                   aclr_n,
  mlp_layer_sequencer_if.master bus
);

  localparam logic [IN_AW-1:0] I_LAST = IN_AW'(LEN - 1);
  localparam logic [3:0]       N_LAST = 4'(NEURONS - 1);
  localparam logic signed [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  state_e                  state_q;
  logic [IN_AW-1:0]        i_q;
  logic [3:0]              n_q;
  logic [W_AW-1:0]         wp_q;
  logic                    vld_q;
  logic                    clken_q;
  logic                    sload_q;
  logic                    zero_q;
  logic                    we_q;
  logic                    busy_q;
  logic                    done_q;
  logic [3:0]              digit_q;
  logic [3:0]              best_q;
  logic signed [OUT_W-1:0] max_q;
  logic signed [OUT_W-1:0] v_w;

  assign v_w = sat_relu(bus.mac_result, SHIFT, RELU != 0);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      n_q     <= '0;
      wp_q    <= '0;
      vld_q   <= 1'b0;
      clken_q <= 1'b0;
      sload_q <= 1'b0;
      zero_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= '0;
      best_q  <= '0;
      max_q   <= '0;
    end else begin
      vld_q   <= 1'b0;
      clken_q <= 1'b0;
      sload_q <= 1'b0;
      zero_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            i_q     <= '0;
            n_q     <= '0;
            wp_q    <= '0;
            max_q   <= MOST_NEG;
            best_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // RAM data for this address is presented next cycle
          vld_q   <= 1'b1;
          clken_q <= 1'b1;
          sload_q <= (i_q == '0);
          wp_q    <= wp_q + W_AW'(1);
          if (i_q == I_LAST) begin
            state_q <= FLUSH;
          end else begin
            i_q <= i_q + IN_AW'(1);
          end
        end
        FLUSH: begin
          // phase 0 presents the last term, phase 1 pushes zeros through
          if (!zero_q) begin
            zero_q  <= 1'b1;
            clken_q <= 1'b1;
          end else begin
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (v_w > max_q) begin
            max_q  <= v_w;
            best_q <= n_q;
          end
          if (n_q == N_LAST) begin
            done_q  <= 1'b1;
            digit_q <= (v_w > max_q) ? n_q : best_q;
            state_q <= DONE;
          end else begin
            n_q     <= n_q + 4'd1;
            i_q     <= '0;
            state_q <= FETCH;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.digit     = digit_q;
  assign bus.x_addr    = i_q;
  assign bus.w_addr    = wp_q;
  assign bus.mac_clken = clken_q;
  assign bus.mac_sload = sload_q;
  assign bus.mac_dataa = vld_q ? bus.x_rdata : '0;
  assign bus.mac_datab = vld_q ? bus.w_rdata : '0;
  assign bus.out_we    = we_q;
  assign bus.out_addr  = n_q;
  assign bus.out_data  = we_q ? v_w : '0;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: three parameterisations, each with
// behavioural RAMs and MAC, driven from a vector table plus a reset sequence.
module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  localparam int NI = 3;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [3:0]  xa;
    logic [5:0]  wa;
    logic        clken;
    logic        sload;
    logic [15:0] da;
    logic [15:0] db;
    logic        we;
    logic [3:0]  oa;
    logic [15:0] od;
  } obs_t;

  typedef struct {
    int                   inst;
    int                   len;
    int                   nn;
    logic [3:0][15:0]     x;
    logic [2:0][3:0][15:0] w;
    logic [2:0][15:0]     ex;
    int                   dig;
    int                   lat;
    bit                   hold;
  } vec_t;

  typedef struct {
    int          inst;
    int          addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n   [NI];
  logic              start_a [NI];
  logic signed [15:0] xmem   [NI][16];
  logic signed [15:0] wmem   [NI][64];
  obs_t              obs     [NI];
  exp_t              sbq     [$];
  vec_t              vecs    [7];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L  = (g == 2) ? 1 : 4;
    localparam int N  = (g == 2) ? 1 : 3;
    localparam int SH = (g == 1) ? 8 : 0;
    localparam int RL = (g == 0) ? 1 : 0;

    mlp_layer_sequencer_if #(.IN_AW(4), .W_AW(6)) ifc ();

    logic signed [15:0] xr, wr, ar, br;
    logic               sl;
    logic signed [32:0] acc, prod;

    assign ifc.start      = start_a[g];
    assign ifc.x_rdata    = xr;
    assign ifc.w_rdata    = wr;
    assign ifc.mac_result = acc;
    assign prod = $signed({{17{ar[15]}}, ar}) * $signed({{17{br[15]}}, br});

    always_ff @(posedge clk) begin
      xr <= xmem[g][ifc.x_addr];
      wr <= wmem[g][ifc.w_addr];
    end

    always_ff @(posedge clk) begin
      if (ifc.mac_clken) begin
        ar  <= ifc.mac_dataa;
        br  <= ifc.mac_datab;
        sl  <= ifc.mac_sload;
        acc <= sl ? prod : acc + prod;
      end
    end

    assign obs[g] = {ifc.busy, ifc.done, ifc.digit, ifc.x_addr,
                     ifc.w_addr, ifc.mac_clken, ifc.mac_sload,
                     ifc.mac_dataa, ifc.mac_datab, ifc.out_we,
                     ifc.out_addr, ifc.out_data};

    mlp_layer_sequencer #(
      .LEN(L), .NEURONS(N), .IN_AW(4), .W_AW(6),
      .SHIFT(SH), .RELU(RL)
    ) dut (
      .clk    (clk),
      .aclr_n (rst_n[g]),
      .bus    (ifc)
    );
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] p4(input int a, b, c, d);
    logic [3:0][15:0] r;
    r[0] = 16'(a);
    r[1] = 16'(b);
    r[2] = 16'(c);
    r[3] = 16'(d);
    return r;
  endfunction

  function automatic logic [2:0][15:0] e3(input int a, b, c);
    logic [2:0][15:0] r;
    r[0] = 16'(a);
    r[1] = 16'(b);
    r[2] = 16'(c);
    return r;
  endfunction

  function automatic vec_t mk(input int inst, len, nn,
                              input logic [3:0][15:0] x,
                              input logic [2:0][3:0][15:0] w,
                              input logic [2:0][15:0] ex,
                              input int dig, lat, input bit hold);
    vec_t v;
    v.inst = inst; v.len = len; v.nn = nn;
    v.x = x; v.w = w; v.ex = ex;
    v.dig = dig; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic load(input int k);
    vec_t v;
    v = vecs[k];
    for (int i = 0; i < v.len; i++) xmem[v.inst][i] = v.x[i];
    for (int n = 0; n < v.nn; n++)
      for (int i = 0; i < v.len; i++)
        wmem[v.inst][n*v.len+i] = v.w[n][i];
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    obs_t o;
    exp_t e;
    int g, cyc, done_cyc, ndone, ck, dig;
    v = vecs[k];
    g = v.inst;
    load(k);
    for (int n = 0; n < v.nn; n++) sbq.push_back('{g, n, v.ex[n]});
    @(negedge clk);
    start_a[g] = 1'b1;
    cyc = 0; done_cyc = -1; ndone = 0; ck = 0; dig = 0;
    while ((done_cyc < 0 || cyc < done_cyc + 3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!v.hold) start_a[g] = 1'b0;
      o = obs[g];
      if (cyc == 1) chk("busy_rise", o.busy, 1);
      if (o.clken) begin
        if (ck == 0) chk("sload_first", o.sload, 1);
        else chk("sload_later", o.sload, 0);
        if (ck == v.len) chk("flush_zero", {o.da, o.db}, 0);
        ck++;
      end
      if (o.we) begin
        chk("clken_per_neuron", ck, v.len + 1);
        ck = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_inst", g, e.inst);
          chk("out_addr", o.oa, e.addr);
          chk("out_data", o.od, e.data);
        end
      end
      if (o.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          dig = o.digit;
          start_a[g] = 1'b0;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_fall", o.busy, 0);
      if (done_cyc >= 0 && cyc == done_cyc + 3) chk("digit_held", o.digit, v.dig);
    end
    start_a[g] = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    else chk("latency", done_cyc, v.lat);
    chk("done_count", ndone, 1);
    chk("digit", dig, v.dig);
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic reset_mid_run();
    obs_t o;
    exp_t e;
    load(0);
    sbq.push_back('{0, 0, vecs[0].ex[0]});
    @(negedge clk);
    start_a[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
      o = obs[0];
      if (o.we) begin
        e = sbq.pop_front();
        chk("pre_reset_addr", o.oa, e.addr);
        chk("pre_reset_data", o.od, e.data);
      end
    end
    o = obs[0];
    chk("mid_fetch_xaddr", o.xa, 1);
    chk("mid_fetch_waddr", o.wa, 5);
    chk("mid_fetch_digit", o.digit, 1);
    rst_n[0] = 1'b0;
    #1;
    chk("reset_async_zero", obs[0], '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_hold_zero", obs[0], '0);
    end
    rst_n[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("after_reset_idle", {obs[0].done, obs[0].we, obs[0].busy}, 0);
    end
    chk("reset_sb_empty", sbq.size(), 0);
  endtask

  initial begin
    vecs[0] = mk(0, 4, 3, p4(1, 2, 3, 4),
                 {p4(-1, -1, -1, -1), p4(2, 0, 0, 1), p4(1, 1, 1, 1)},
                 e3(10, 6, 0), 0, 22, 1'b0);
    vecs[1] = mk(0, 4, 3, p4(1, 2, 3, 4),
                 {p4(0, 25, 0, 0), p4(50, 0, 0, 0), p4(1, 1, 1, 1)},
                 e3(10, 50, 50), 1, 22, 1'b0);
    vecs[2] = mk(1, 4, 3, p4(32767, 32767, 32767, 32767),
                 {p4(1, 0, 0, 0), p4(-32768, -32768, -32768, -32768),
                  p4(32767, 32767, 32767, 32767)},
                 e3(32767, -32768, 127), 0, 22, 1'b0);
    vecs[3] = mk(1, 4, 3, p4(32767, 32767, 32767, 32767),
                 {p4(-1, 0, 0, 0), p4(1, 0, 0, 0), p4(0, 0, 0, 0)},
                 e3(0, 127, -128), 1, 22, 1'b0);
    vecs[4] = mk(2, 1, 1, p4(-5, 0, 0, 0),
                 {p4(0, 0, 0, 0), p4(0, 0, 0, 0), p4(3, 0, 0, 0)},
                 e3(-15, 0, 0), 0, 5, 1'b0);
    vecs[5] = mk(2, 1, 1, p4(100, 0, 0, 0),
                 {p4(0, 0, 0, 0), p4(0, 0, 0, 0), p4(-3, 0, 0, 0)},
                 e3(-300, 0, 0), 0, 5, 1'b0);
    vecs[6] = vecs[0];
    vecs[6].hold = 1'b1;

    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0;
      start_a[g] = 1'b0;
    end
    for (int g = 0; g < NI; g++)
      for (int a = 0; a < 64; a++) begin
        wmem[g][a] = '0;
        if (a < 16) xmem[g][a] = '0;
      end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk("reset_state", obs[g], '0);
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
    @(negedge clk);

    run_vec(0);
    run_vec(1);
    reset_mid_run();
    run_vec(6);
    for (int k = 2; k <= 5; k++) run_vec(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Sequences the shared signed 16x16 multiply-accumulate unit through one fully connected layer of the digit classifier.
- For each of NEURONS outputs it streams LEN input/weight pairs from synchronous RAMs into the MAC, flushes the MAC pipeline and captures the 33-bit sum.
- It then scales, saturates and optionally ReLUs the sum, writes the result to the output RAM and tracks the arg-max neuron as the recognized digit.

Parameters:
- LEN, 784: terms per dot product (inputs per neuron), >= 1.
- NEURONS, 10: output neurons in the layer, >= 1.
- IN_AW, 10: input RAM address width, 2**IN_AW >= LEN.
- W_AW, 13: weight RAM address width, 2**W_AW >= LEN*NEURONS.
- SHIFT, 8: arithmetic right shift applied to the accumulator.
- RELU, 1: 1 clamps negative results to 0; 0 passes them through.

Ports:
- clk  in  1  system clock.
- aclr_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the layer; ignored unless busy=0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the layer is complete.
- digit  out  4  arg-max neuron index; valid from done, held until the next done.
- x_addr  out  IN_AW  input RAM address (read data returns 1 cycle later).
- x_rdata  in  16  signed input sample.
- w_addr  out  W_AW  weight RAM address, n*LEN+i.
- w_rdata  in  16  signed weight.
- mac_clken  out  1  MAC clock enable.
- mac_sload  out  1  MAC clear-on-first-term.
- mac_dataa  out  16  signed, to MAC.
- mac_datab  out  16  signed, to MAC.
- mac_result  in  33  MAC accumulator output.
- out_we  out  1  output RAM write strobe.
- out_addr  out  4  output RAM address = neuron index.
- out_data  out  16  signed post-processed neuron value.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While aclr_n=0 the FSM goes to IDLE and all outputs are 0, including digit, the counters and the running max. Reset mid-layer abandons the run: no done pulse, and out_we stays 0.
- States: IDLE, FETCH, FLUSH, WRITE, DONE.
- IDLE: on start, set n=0, i=0, max=most-negative, digit register unchanged; go to FETCH.
- FETCH: drive x_addr=i and w_addr=n*LEN+i (running pointer, no multiplier); i++. After i=LEN-1 is issued, go to FLUSH.
- Term delay: a 1-cycle delayed valid/first pair tracks the RAM latency. In the cycle after each issue:
  - mac_clken=1, mac_dataa=x_rdata, mac_datab=w_rdata;
  - mac_sload=1 only for term i=0.
- FLUSH (1 cycle): the last term is presented this cycle, with clken. Then one extra cycle follows with mac_clken=1, mac_sload=0 and mac_dataa=mac_datab=0, so the final product is added and zero enters the MAC input registers.
- WRITE (1 cycle): sample mac_result, which now holds the full sum, and post-process:
  - v = mac_result >>> SHIFT (sign-preserving);
  - saturate v to [-32768, 32767];
  - if RELU=1 and v<0, v=0.
  - Drive out_we=1, out_addr=n, out_data=v.
  - If v > max (strict), max=v and best=n; ties keep the lower index.
  - If n=NEURONS-1, go to DONE; else n++, i=0, go to FETCH.
- DONE (1 cycle): done=1, digit=best, busy=0 in the following IDLE.
- mac_clken=0 in every cycle not listed above.
- Latency: a neuron takes LEN+3 cycles (LEN issue + RAM + flush + write). The layer takes NEURONS*(LEN+3)+1 cycles from start to done.
- start while busy: ignored, no queuing.
- start in the same cycle as done: ignored. start is honoured only in IDLE.
- Overflow: the MAC sum is 33 bits and is never wrapped by this block. Saturation applies only after the shift.

Decomposition:
- Package mlp_pkg:
  - state enum (IDLE, FETCH, FLUSH, WRITE, DONE);
  - localparams DATA_W=16, ACC_W=33, OUT_W=16;
  - a function sat_relu(acc, shift, relu) returning OUT_W.
- No sub-modules: the MAC is instantiated beside this block at the top level, not inside it.

Test Plan:
- Bench config LEN=4, NEURONS=3, SHIFT=0, RELU=1, with a behavioural MAC model. x=[1,2,3,4]; weights n0=[1,1,1,1], n1=[2,0,0,1], n2=[-1,-1,-1,-1] -> out_data=10, 6, 0 at addrs 0..2; digit=0; done exactly 22 cycles after start.
- SHIFT=8, x=[32767 x4], w=[32767 x4] -> sum 4294705156 >>>8 saturates -> out_data=32767.
- RELU=0, neuron sum -300 with SHIFT=0 -> out_data=-300. Tie case: n1 and n2 both 50, n0=10 -> digit=1.
- Assert start every cycle while busy -> exactly one done per layer. Check that each neuron's first clken carries mac_sload=1, and that the flush cycle has zero data.
- Drop aclr_n mid-FETCH of neuron 1 -> all outputs 0 immediately. No done pulse. A fresh start afterwards completes with correct results.
- LEN=1, NEURONS=1, x=[-5], w=[3], RELU=0 -> out_data=-15, digit=0; done 5 cycles after start.
